mul_acc_multi: RTL

MUL_ACC_MULTI -- requirements
Module: mul_acc_multi

---
 rtl/mul_acc_multi.sv | 121 ++++++++++++
 1 files changed

// File: rtl/mul_acc_multi.sv
// mul_acc_multi: pipelined N_TERM-way signed multiply-accumulate with frame control.
// Define MUL_ACC_MULTI_SAT_EN to saturate the accumulator instead of wrapping.
module mul_acc_multi #(
   parameter int IN_BW   = 42,
   parameter int OUT_BW  = 52,
   parameter int N_TERM  = 2,
   parameter int FRAC_SH = 16,
   parameter int MUL_LAT = 2
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_start,
   input  logic                    i_valid,
   input  logic                    i_last,
   input  logic [N_TERM*IN_BW-1:0] i_a,
   input  logic [N_TERM*IN_BW-1:0] i_b,
   output logic [OUT_BW-1:0]       o_data,
   output logic                    o_valid,
   output logic                    o_busy,
   output logic                    o_ovf
);

   localparam int PW = 2 * IN_BW;

`ifdef MUL_ACC_MULTI_SAT_EN
   localparam logic [OUT_BW-1:0] ACC_MAX = {1'b0, {(OUT_BW-1){1'b1}}};
   localparam logic [OUT_BW-1:0] ACC_MIN = {1'b1, {(OUT_BW-1){1'b0}}};
`endif

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t                   r_state;
   logic signed [PW-1:0]     r_p [MUL_LAT][N_TERM];
   logic [MUL_LAT:0]         r_vp;
   logic [MUL_LAT:0]         r_lp;
   logic signed [OUT_BW-1:0] r_s;
   logic signed [OUT_BW-1:0] r_acc;
   logic                     r_done;
   logic                     r_valid;
   logic                     r_ovf;

   logic                     w_take;
   logic signed [OUT_BW-1:0] w_s;
   logic signed [OUT_BW-1:0] w_add;
   logic                     w_ovf;

   assign w_take = i_valid & (i_start | (r_state == RUN));

   // Product pipeline carries data only; validity travels in r_vp/r_lp.
   always_ff @(posedge i_clk) begin
      for (int k = 0; k < N_TERM; k++) begin
         r_p[0][k] <= PW'($signed(i_a[k*IN_BW +: IN_BW]))
                    * PW'($signed(i_b[k*IN_BW +: IN_BW]));
         for (int j = 1; j < MUL_LAT; j++)
            r_p[j][k] <= r_p[j-1][k];
      end
   end

   always_comb begin
      w_s = '0;
      for (int k = 0; k < N_TERM; k++)
         w_s = w_s + OUT_BW'(r_p[MUL_LAT-1][k] >>> FRAC_SH);
      w_add = r_acc + r_s;
      w_ovf = (r_acc[OUT_BW-1] == r_s[OUT_BW-1])
           && (w_add[OUT_BW-1] != r_acc[OUT_BW-1]);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
         r_vp    <= '0;
         r_lp    <= '0;
         r_s     <= '0;
         r_acc   <= '0;
         r_done  <= 1'b0;
         r_valid <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_s     <= w_s;
         r_valid <= 1'b0;
         if (i_start) begin
            // A new frame discards everything in flight.
            r_vp    <= {{MUL_LAT{1'b0}}, w_take};
            r_lp    <= {{MUL_LAT{1'b0}}, w_take & i_last};
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_done  <= 1'b0;
            r_state <= (w_take & i_last) ? DRAIN : RUN;
         end else begin
            r_vp   <= {r_vp[MUL_LAT-1:0], w_take};
            r_lp   <= {r_lp[MUL_LAT-1:0], w_take & i_last};
            r_done <= r_vp[MUL_LAT] & r_lp[MUL_LAT];
            if (r_vp[MUL_LAT]) begin
               if (w_ovf)
                  r_ovf <= 1'b1;
`ifdef MUL_ACC_MULTI_SAT_EN
               if (!r_ovf)
                  r_acc <= w_ovf ? (r_s[OUT_BW-1] ? ACC_MIN : ACC_MAX) : w_add;
`else
               r_acc <= w_add;
`endif
            end
            unique case (r_state)
               IDLE:  r_state <= IDLE;
               RUN:   if (w_take & i_last) r_state <= DRAIN;
               DRAIN: if (r_done) begin
                  r_state <= IDLE;
                  r_valid <= 1'b1;
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   assign o_data  = r_acc;
   assign o_valid = r_valid;
   assign o_busy  = (r_state != IDLE);
   assign o_ovf   = r_ovf;

endmodule
